// File: rtl/seven_seg_capture_pkg.sv
// Shared 7-segment definitions: active-low segment patterns, nibble types and the
// segment-to-hex decoder used by the capture block (and by the display encoder).
package seven_seg_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;
  typedef logic [2:0] digit_idx_t;

  typedef struct packed {
    logic    valid;
    nibble_t nibble;
  } hex_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  function automatic hex_t seg_to_hex(input seg_t s);
    hex_t r;
    r.valid  = 1'b1;
    r.nibble = 4'h0;
    case (s)
      SEG_0:   r.nibble = 4'h0;
      SEG_1:   r.nibble = 4'h1;
      SEG_2:   r.nibble = 4'h2;
      SEG_3:   r.nibble = 4'h3;
      SEG_4:   r.nibble = 4'h4;
      SEG_5:   r.nibble = 4'h5;
      SEG_6:   r.nibble = 4'h6;
      SEG_7:   r.nibble = 4'h7;
      SEG_8:   r.nibble = 4'h8;
      SEG_9:   r.nibble = 4'h9;
      SEG_A:   r.nibble = 4'hA;
      SEG_B:   r.nibble = 4'hB;
      SEG_C:   r.nibble = 4'hC;
      SEG_D:   r.nibble = 4'hD;
      SEG_E:   r.nibble = 4'hE;
      SEG_F:   r.nibble = 4'hF;
      default: r.valid  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_capture_if.sv
// Bus between the display path / consumer (master) and the capture block (slave).
// blank_mask exists only when SEVEN_SEG_CAPTURE_BLANK_EN is defined.
interface seven_seg_capture_if #(parameter int N_DIGITS = 4);
  import seven_seg_pkg::*;

  seg_t                  seg;
  logic [N_DIGITS-1:0]   an;
  logic [4*N_DIGITS-1:0] frame_data;
  logic                  frame_valid;
  logic                  frame_ready;
  logic                  digit_err;
  logic                  overrun;
  logic                  err_clr;
`ifdef SEVEN_SEG_CAPTURE_BLANK_EN
  logic [N_DIGITS-1:0]   blank_mask;

  modport master (output seg, an, frame_ready, err_clr,
                  input  frame_data, frame_valid, digit_err, overrun, blank_mask);
  modport slave  (input  seg, an, frame_ready, err_clr,
                  output frame_data, frame_valid, digit_err, overrun, blank_mask);
`else
  modport master (output seg, an, frame_ready, err_clr,
                  input  frame_data, frame_valid, digit_err, overrun);
  modport slave  (input  seg, an, frame_ready, err_clr,
                  output frame_data, frame_valid, digit_err, overrun);
`endif

endinterface

// File: rtl/seven_seg_capture_stability.sv
// Registers the raw (seg, an) bus once and emits one capture strobe per stable dwell
// of a single selected digit, together with that digit's index and pattern.
module seven_seg_stability
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  seg_t                i_seg,
  input  logic [N_DIGITS-1:0] i_an,
  output logic                o_cap,
  output digit_idx_t          o_idx,
  output seg_t                o_seg
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  seg_t                r_smp_seg, r_prev_seg, r_seg;
  logic [N_DIGITS-1:0] r_smp_an, r_prev_an;
  logic [1:0]          r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_cap, w_cap, w_onehot, w_same;
  digit_idx_t          r_idx, w_idx;

  // Classify the registered sample: single digit selected, which one, unchanged or not.
  always_comb begin
    w_onehot = $onehot(~r_smp_an);
    w_same   = (r_smp_an == r_prev_an) && (r_smp_seg == r_prev_seg);
    w_idx    = 3'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      w_idx = r_smp_an[i] ? w_idx : 3'(i);
    end
  end

  // Dwell tracking; reaching the threshold captures once and parks in LOCKED.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cap       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_onehot) begin
          w_state_nxt = ST_TRACK;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      ST_TRACK: begin
        if (!w_onehot) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_same) begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end else begin
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (!w_onehot) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (!w_same) begin
          w_state_nxt = ST_TRACK;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    if ((w_state_nxt == ST_TRACK) && (w_cnt_nxt == CNT_W'(STABLE_CYCLES))) begin
      w_cap       = 1'b1;
      w_state_nxt = ST_LOCKED;
    end else begin
      w_cap       = 1'b0;
    end
  end

  // Input sample, previous sample, FSM state and the registered capture strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp_seg  <= 7'h7F;
      r_smp_an   <= '1;
      r_prev_seg <= 7'h7F;
      r_prev_an  <= '1;
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_cap      <= 1'b0;
      r_idx      <= 3'd0;
      r_seg      <= 7'h7F;
    end else begin
      r_smp_seg  <= i_seg;
      r_smp_an   <= i_an;
      r_prev_seg <= r_smp_seg;
      r_prev_an  <= r_smp_an;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cap      <= w_cap;
      r_idx      <= w_idx;
      r_seg      <= r_smp_seg;
    end
  end

  assign o_cap = r_cap;
  assign o_idx = r_idx;
  assign o_seg = r_seg;

endmodule

// File: rtl/seven_seg_capture.sv
// Loopback capture of a multiplexed 7-segment display into whole frames on a valid/ready bus.
// Define SEVEN_SEG_CAPTURE_BLANK_EN to accept an all-off digit as blank (adds blank_mask).
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic                clk,
  input logic                rst_n,
  seven_seg_capture_if.slave bus
);

  logic                  w_cap, w_blank, w_cap_ok, w_cap_bad;
  logic                  w_complete, w_accept, w_ovr_set;
  digit_idx_t            w_idx;
  seg_t                  w_cap_seg;
  hex_t                  w_hex;
  logic [N_DIGITS-1:0]   w_hit, r_seen, w_seen_nxt;
  logic [4*N_DIGITS-1:0] r_shadow, w_shadow_nxt, r_frame;
  logic                  r_valid, r_err, r_ovr;

  seven_seg_stability #(
    .N_DIGITS      (N_DIGITS),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stab (
    .clk   (clk),
    .rst_n (rst_n),
    .i_seg (bus.seg),
    .i_an  (bus.an),
    .o_cap (w_cap),
    .o_idx (w_idx),
    .o_seg (w_cap_seg)
  );

  // Decode the captured pattern and split the strobe into good and bad captures.
  always_comb begin
    w_hex = seg_to_hex(w_cap_seg);
`ifdef SEVEN_SEG_CAPTURE_BLANK_EN
    w_blank = (w_cap_seg == SEG_BLANK);
`else
    w_blank = 1'b0;
`endif
    w_cap_ok  = w_cap & (w_hex.valid | w_blank);
    w_cap_bad = w_cap & ~(w_hex.valid | w_blank);
  end

  // Shadow/seen update; a completing frame clears seen before the same-cycle capture lands.
  always_comb begin
    w_complete   = &r_seen;
    w_accept     = r_valid & bus.frame_ready;
    w_ovr_set    = w_complete & r_valid & ~w_accept;
    w_seen_nxt   = w_complete ? '0 : r_seen;
    w_shadow_nxt = r_shadow;
    for (int i = 0; i < N_DIGITS; i++) begin
      w_hit[i]                = w_cap_ok && (w_idx == 3'(i));
      w_seen_nxt[i]           = w_seen_nxt[i] | w_hit[i];
      w_shadow_nxt[4*i +: 4]  = w_hit[i] ? w_hex.nibble : r_shadow[4*i +: 4];
    end
  end

  // Frame assembly, handshake and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen   <= '0;
      r_shadow <= '0;
      r_frame  <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_seen   <= w_seen_nxt;
      r_shadow <= w_shadow_nxt;
      if (w_complete && (!r_valid || w_accept)) begin
        r_frame <= r_shadow;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
      if (bus.err_clr) begin
        r_err <= 1'b0;
        r_ovr <= 1'b0;
      end else begin
        r_err <= r_err | w_cap_bad;
        r_ovr <= r_ovr | w_ovr_set;
      end
    end
  end

`ifdef SEVEN_SEG_CAPTURE_BLANK_EN
  logic [N_DIGITS-1:0] r_blank_shadow, r_blank_mask;

  // Blank flags follow the nibble slots and are published together with frame_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blank_shadow <= '0;
      r_blank_mask   <= '0;
    end else begin
      for (int i = 0; i < N_DIGITS; i++) begin
        r_blank_shadow[i] <= w_hit[i] ? w_blank : r_blank_shadow[i];
      end
      if (w_complete && (!r_valid || w_accept)) begin
        r_blank_mask <= r_blank_shadow;
      end else begin
        r_blank_mask <= r_blank_mask;
      end
    end
  end

  assign bus.blank_mask = r_blank_mask;
`endif

  assign bus.frame_data  = r_frame;
  assign bus.frame_valid = r_valid;
  assign bus.digit_err   = r_err;
  assign bus.overrun     = r_ovr;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: directed scenarios plus random scans,
// compared every cycle against a dwell/frame-level reference model.
module tb_seven_seg_capture;

  localparam int N = 4;
  localparam int S = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_seg_capture_if #(.N_DIGITS(N)) bus_if ();

  seven_seg_capture #(.N_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int vcount   = 0;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {
    int         due;
    int         idx;
    logic [6:0] seg;
  } cap_t;

  cap_t       cap_q [$];
  logic [3:0] m_shadow [N];
  logic [N-1:0] m_blank = '0, m_seen = '0, m_bmask = '0;
  logic [15:0] m_frame = '0;
  logic m_valid = 1'b0, m_err = 1'b0, m_ovr = 1'b0;
  logic [3:0] run_an = '1;
  logic [6:0] run_seg = '1;
  int run_len = 0;
  int edge_no = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a digit is captured once when the same one-hot-low (an, seg) has been
  // presented for S consecutive edges; it lands in the shadow two edges later and a
  // full shadow is published on the edge after that.
  task automatic model_step();
    logic err_set, ovr_set, found;
    logic [3:0] nib;
    cap_t c;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_shadow[i] = 4'h0;
      m_blank = '0; m_seen = '0; m_bmask = '0; m_frame = '0;
      m_valid = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
      run_len = 0; cap_q.delete();
      return;
    end
    edge_no++;
    err_set = 1'b0;
    ovr_set = 1'b0;
    if (m_seen == {N{1'b1}}) begin
      if (!m_valid || bus_if.frame_ready) begin
        for (int i = 0; i < N; i++) m_frame[4*i +: 4] = m_shadow[i];
        m_bmask = m_blank;
        m_valid = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
      m_seen = '0;
    end else if (m_valid && bus_if.frame_ready) begin
      m_valid = 1'b0;
    end
    while (cap_q.size() > 0 && cap_q[0].due == edge_no) begin
      c = cap_q.pop_front();
      found = 1'b0;
      nib = 4'h0;
      for (int j = 0; j < 16; j++) begin
        if (seg_tab[j] == c.seg) begin found = 1'b1; nib = 4'(j); end
      end
`ifdef SEVEN_SEG_CAPTURE_BLANK_EN
      if (c.seg == 7'b1111111) found = 1'b1;
`endif
      if (found) begin
        m_shadow[c.idx] = nib;
        m_blank[c.idx]  = (c.seg == 7'b1111111);
        m_seen[c.idx]   = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end
    if (bus_if.err_clr) begin
      m_err = 1'b0; m_ovr = 1'b0;
    end else begin
      m_err = m_err | err_set; m_ovr = m_ovr | ovr_set;
    end
    if (run_len > 0 && bus_if.an == run_an && bus_if.seg == run_seg) begin
      run_len++;
    end else begin
      run_len = 1; run_an = bus_if.an; run_seg = bus_if.seg;
    end
    if ($countones(~run_an) == 1 && run_len == S) begin
      c.due = edge_no + 2;
      c.seg = run_seg;
      c.idx = 0;
      for (int i = 0; i < N; i++) if (!run_an[i]) c.idx = i;
      cap_q.push_back(c);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("frame_data", 32'(bus_if.frame_data), 32'(m_frame));
    chk("frame_valid", 32'(bus_if.frame_valid), 32'(m_valid));
    chk("digit_err", 32'(bus_if.digit_err), 32'(m_err));
    chk("overrun", 32'(bus_if.overrun), 32'(m_ovr));
`ifdef SEVEN_SEG_CAPTURE_BLANK_EN
    chk("blank_mask", 32'(bus_if.blank_mask), 32'(m_bmask));
`endif
    if (bus_if.frame_valid === 1'b1) vcount++;
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus_if.an  = an;
      bus_if.seg = seg;
    end
  endtask

  task automatic idle(input int n);
    drive(4'b1111, 7'b1111111, n);
  endtask

  task automatic scan(input logic [6:0] d0, input logic [6:0] d1, input logic [6:0] d2,
                      input logic [6:0] d3, input int hold);
    drive(4'b1110, d0, hold);
    drive(4'b1101, d1, hold);
    drive(4'b1011, d2, hold);
    drive(4'b0111, d3, hold);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus_if.err_clr = 1'b1;
    @(negedge clk);
    bus_if.err_clr = 1'b0;
  endtask

  initial begin
    logic [3:0] an_r;
    logic [6:0] seg_r;
    bus_if.an = 4'b1111;
    bus_if.seg = 7'b1111111;
    bus_if.frame_ready = 1'b1;
    bus_if.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_frame_data", 32'(bus_if.frame_data), 32'h0);
    chk("reset_frame_valid", 32'(bus_if.frame_valid), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Basic scan 1,2,3,4 with consumer ready
    vcount = 0;
    scan(seg_tab[1], seg_tab[2], seg_tab[3], seg_tab[4], 6);
    idle(6);
    chk("scan_1234_data", 32'(bus_if.frame_data), 32'h4321);
    chk("scan_1234_pulse", 32'(vcount), 32'd1);
    chk("scan_1234_err", 32'(bus_if.digit_err), 32'h0);

    // Dwell too short: nothing captured
    vcount = 0;
    scan(seg_tab[5], seg_tab[6], seg_tab[7], seg_tab[8], 3);
    idle(6);
    chk("short_dwell_valid", 32'(vcount), 32'd0);
    chk("short_dwell_data", 32'(bus_if.frame_data), 32'h4321);

    // Undecodable pattern on digit 2
    drive(4'b1011, 7'b1010101, 6);
    idle(4);
    chk("bad_pattern_err", 32'(bus_if.digit_err), 32'h1);
    chk("bad_pattern_valid", 32'(bus_if.frame_valid), 32'h0);
    pulse_clr();
    @(negedge clk);
    chk("err_clr", 32'(bus_if.digit_err), 32'h0);

    // Overrun: two frames with the consumer stalled
    bus_if.frame_ready = 1'b0;
    scan(seg_tab[10], seg_tab[11], seg_tab[12], seg_tab[13], 6);
    scan(seg_tab[10], seg_tab[11], seg_tab[12], seg_tab[13], 6);
    idle(4);
    chk("overrun_data", 32'(bus_if.frame_data), 32'hDCBA);
    chk("overrun_valid", 32'(bus_if.frame_valid), 32'h1);
    chk("overrun_flag", 32'(bus_if.overrun), 32'h1);
    @(negedge clk);
    bus_if.frame_ready = 1'b1;
    @(negedge clk);
    chk("accept_drops_valid", 32'(bus_if.frame_valid), 32'h0);
    pulse_clr();
    @(negedge clk);
    chk("overrun_clr", 32'(bus_if.overrun), 32'h0);

    // Reset in the middle of a frame
    drive(4'b1110, seg_tab[5], 6);
    drive(4'b1101, seg_tab[6], 6);
    @(negedge clk);
    rst_n = 1'b0;
    idle(3);
    chk("midreset_data", 32'(bus_if.frame_data), 32'h0);
    rst_n = 1'b1;
    scan(seg_tab[5], seg_tab[6], seg_tab[7], seg_tab[8], 6);
    idle(6);
    chk("post_reset_data", 32'(bus_if.frame_data), 32'h8765);

    // Two digits selected at once
    drive(4'b1100, seg_tab[1], 10);
    idle(4);
    chk("two_low_err", 32'(bus_if.digit_err), 32'h0);
    chk("two_low_data", 32'(bus_if.frame_data), 32'h8765);

`ifdef SEVEN_SEG_CAPTURE_BLANK_EN
    vcount = 0;
    scan(seg_tab[1], seg_tab[2], seg_tab[3], 7'b1111111, 6);
    idle(6);
    chk("blank_mask", 32'(bus_if.blank_mask), 32'h8);
    chk("blank_data", 32'(bus_if.frame_data), 32'h0321);
    chk("blank_pulse", 32'(vcount), 32'd1);
`endif

    // Random dwells: mostly legal digits, some junk, random consumer and clears
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 99) < 85) begin
        an_r = 4'b1111;
        an_r[$urandom_range(0, 3)] = 1'b0;
      end else begin
        an_r = 4'($urandom_range(0, 15));
      end
      case ($urandom_range(0, 9))
        0:       seg_r = 7'b1111111;
        1:       seg_r = 7'($urandom_range(0, 127));
        default: seg_r = seg_tab[$urandom_range(0, 15)];
      endcase
      bus_if.frame_ready = ($urandom_range(0, 2) != 0);
      bus_if.err_clr = ($urandom_range(0, 19) == 0);
      drive(an_r, seg_r, $urandom_range(1, 7));
    end
    bus_if.err_clr = 1'b0;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
